// File: rtl/scarf_spi_frontend_if.sv
// -----------------------------------------------------------------------------
// scarf_spi_frontend_if
// Groups the SPI pins and the slave-facing broadcast bus of the SCARF SPI
// front end.
//   sclk, mosi, ss_n : SPI host -> front end (mode 0, MSB first, ss_n active-low)
//   miso             : front end -> SPI host
//   data_out/_valid  : last completed payload byte and its one-cycle strobe
//   data_out_finished: one-cycle strobe at frame end
//   slave_id, rnw    : decoded header byte of the current frame
//   read_data_in     : OR of all slave read buses, serialised onto miso
// Modport slave is used by the front end; modport master by whatever drives
// the SPI pins and consumes the broadcast bus.
// -----------------------------------------------------------------------------
interface scarf_spi_frontend_if;
    logic       sclk;
    logic       mosi;
    logic       ss_n;
    logic       miso;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_finished;
    logic [6:0] slave_id;
    logic       rnw;
    logic [7:0] read_data_in;

    modport slave (
        input  sclk, mosi, ss_n, read_data_in,
        output miso, data_out, data_out_valid, data_out_finished, slave_id, rnw
    );

    modport master (
        output sclk, mosi, ss_n, read_data_in,
        input  miso, data_out, data_out_valid, data_out_finished, slave_id, rnw
    );
endinterface

// File: rtl/scarf_spi_frontend.sv
// -----------------------------------------------------------------------------
// scarf_spi_frontend
// SPI mode-0 slave front end. Oversamples sclk/mosi/ss_n in the clk domain,
// decodes a header byte (rnw + 7-bit slave id) and broadcasts every later
// byte on data_out with a one-cycle valid strobe. After any completed byte the
// next sclk fall loads read_data_in into the tx shifter, which drives miso.
// Ports:
//   clk        : system clock (must be >= 8x sclk)
//   rst_n_sync : asynchronous active-low reset
//   spi        : scarf_spi_frontend_if.slave (SPI pins + broadcast bus)
// -----------------------------------------------------------------------------
module scarf_spi_frontend #(
    parameter int SYNC_STAGES = 2
) (
    input  logic                        clk,
    input  logic                        rst_n_sync,
    scarf_spi_frontend_if.slave         spi
);

    localparam logic [1:0] FILL_DONE = 2'(SYNC_STAGES);

    // synchronizer chains, oldest sample in the MSB
    logic [SYNC_STAGES-1:0] sclk_sync_r;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic [SYNC_STAGES-1:0] ss_n_sync_r;

    logic       sclk_d_r;
    logic       ss_n_d_r;
    logic [1:0] fill_cnt_r;
    logic       armed_r;

    logic       sclk_s;
    logic       mosi_s;
    logic       ss_n_s;
    logic       sclk_rise_s;
    logic       sclk_fall_s;
    logic       ss_fall_s;
    logic       ss_rise_s;
    logic [7:0] rx_next_s;

    logic       active_r;
    logic [2:0] bit_cnt_r;
    logic [1:0] byte_cnt_r;
    logic [7:0] rx_r;
    logic [7:0] tx_r;
    logic       hdr_done_r;
    logic       load_pending_r;
    logic       byte_done_r;
    logic       byte_hdr_r;
    logic [7:0] data_out_r;
    logic       valid_r;
    logic       finished_r;
    logic [6:0] slave_id_r;
    logic       rnw_r;
    logic       miso_r;

    assign sclk_s      = sclk_sync_r[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_r[SYNC_STAGES-1];
    assign ss_n_s      = ss_n_sync_r[SYNC_STAGES-1];
    assign sclk_rise_s = sclk_s & ~sclk_d_r;
    assign sclk_fall_s = ~sclk_s & sclk_d_r;
    assign ss_fall_s   = ~ss_n_s & ss_n_d_r;
    assign ss_rise_s   = ss_n_s & ~ss_n_d_r;
    assign rx_next_s   = {rx_r[6:0], mosi_s};

    assign spi.miso              = miso_r;
    assign spi.data_out          = data_out_r;
    assign spi.data_out_valid    = valid_r;
    assign spi.data_out_finished = finished_r;
    assign spi.slave_id          = slave_id_r;
    assign spi.rnw               = rnw_r;

    // Input synchronizers; ss_n idles high so reset release is not a frame edge.
    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            sclk_sync_r <= {SYNC_STAGES{1'b0}};
            mosi_sync_r <= {SYNC_STAGES{1'b0}};
            ss_n_sync_r <= {SYNC_STAGES{1'b1}};
        end else begin
            sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], spi.sclk};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], spi.mosi};
            ss_n_sync_r <= {ss_n_sync_r[SYNC_STAGES-2:0], spi.ss_n};
        end
    end

    // Edge-detect delay flops and the arming logic. The chain's reset value of
    // 1 is not a real observation, so frame starts are only accepted once the
    // chain has been refilled from the pin and ss_n was genuinely seen high;
    // this makes a frame already in progress at reset release invisible.
    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            sclk_d_r   <= 1'b0;
            ss_n_d_r   <= 1'b1;
            fill_cnt_r <= 2'd0;
            armed_r    <= 1'b0;
        end else begin
            sclk_d_r <= sclk_s;
            ss_n_d_r <= ss_n_s;
            if (fill_cnt_r != FILL_DONE) begin
                fill_cnt_r <= fill_cnt_r + 2'd1;
            end
            if ((fill_cnt_r == FILL_DONE) && ss_n_s) begin
                armed_r <= 1'b1;
            end
        end
    end

    // Frame engine: bit/byte counting, header decode, payload broadcast,
    // tx shifting onto miso, and the end-of-frame strobe.
    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            active_r       <= 1'b0;
            bit_cnt_r      <= 3'd0;
            byte_cnt_r     <= 2'd0;
            rx_r           <= 8'd0;
            tx_r           <= 8'd0;
            hdr_done_r     <= 1'b0;
            load_pending_r <= 1'b0;
            byte_done_r    <= 1'b0;
            byte_hdr_r     <= 1'b0;
            data_out_r     <= 8'd0;
            valid_r        <= 1'b0;
            finished_r     <= 1'b0;
            slave_id_r     <= 7'd0;
            rnw_r          <= 1'b0;
            miso_r         <= 1'b0;
        end else begin
            valid_r     <= 1'b0;
            finished_r  <= 1'b0;
            byte_done_r <= 1'b0;

            // A byte completed last cycle: commit it one edge later from rx.
            if (byte_done_r) begin
                if (byte_hdr_r) begin
                    slave_id_r <= rx_r[6:0];
                    rnw_r      <= rx_r[7];
                end else begin
                    data_out_r <= rx_r;
                    valid_r    <= 1'b1;
                end
            end else if (finished_r) begin
                // header stays visible during the finished strobe only
                slave_id_r <= 7'd0;
                rnw_r      <= 1'b0;
            end

            if (!active_r) begin
                miso_r <= 1'b0;
                tx_r   <= 8'd0;
                if (ss_fall_s && armed_r) begin
                    active_r       <= 1'b1;
                    bit_cnt_r      <= 3'd0;
                    byte_cnt_r     <= 2'd0;
                    rx_r           <= 8'd0;
                    hdr_done_r     <= 1'b0;
                    load_pending_r <= 1'b0;
                end
            end else if (ss_rise_s) begin
                // frame end wins over a coincident sclk rise; partial bits drop
                active_r       <= 1'b0;
                finished_r     <= 1'b1;
                bit_cnt_r      <= 3'd0;
                hdr_done_r     <= 1'b0;
                load_pending_r <= 1'b0;
                tx_r           <= 8'd0;
                miso_r         <= 1'b0;
            end else begin
                if (sclk_rise_s) begin
                    rx_r      <= rx_next_s;
                    bit_cnt_r <= bit_cnt_r + 3'd1;
                    if (bit_cnt_r == 3'd7) begin
                        byte_done_r    <= 1'b1;
                        byte_hdr_r     <= (byte_cnt_r == 2'd0);
                        load_pending_r <= 1'b1;
                        hdr_done_r     <= 1'b1;
                        if (byte_cnt_r != 2'd2) begin
                            byte_cnt_r <= byte_cnt_r + 2'd1;
                        end
                    end
                end else if (sclk_fall_s && hdr_done_r) begin
                    if (load_pending_r) begin
                        tx_r           <= spi.read_data_in;
                        miso_r         <= spi.read_data_in[7];
                        load_pending_r <= 1'b0;
                    end else begin
                        tx_r   <= {tx_r[6:0], 1'b0};
                        miso_r <= tx_r[6];
                    end
                end
            end
        end
    end

endmodule
